// File: rtl/syst_ws_pkg.sv
// Shared sizing and lane-vector types for the weight-stationary array stream wrapper.
package syst_ws_pkg;

   localparam int unsigned N_IN    = 3;
   localparam int unsigned N_OUT   = 2;
   localparam int unsigned X_WIDTH = 8;
   localparam int unsigned W_WIDTH = 8;
   localparam int unsigned Y_WIDTH = X_WIDTH + W_WIDTH + N_IN;
   localparam int unsigned LAT     = N_IN + N_OUT + 1;

   typedef logic [N_IN-1:0][X_WIDTH-1:0]  x_vec_t;
   typedef logic [N_OUT-1:0][Y_WIDTH-1:0] y_vec_t;

endpackage

// File: rtl/syst_ws_stream_if.sv
// Input stream, array lanes and result stream of syst_ws_stream bundled together.
interface syst_ws_stream_if;
   import syst_ws_pkg::*;

   logic   s_valid_i;
   logic   s_ready_o;
   x_vec_t s_x_i;
   x_vec_t arr_x_o;
   y_vec_t arr_y_i;
   logic   m_valid_o;
   logic   m_ready_i;
   y_vec_t m_y_o;

   modport slave (
      input  s_valid_i, s_x_i, arr_y_i, m_ready_i,
      output s_ready_o, arr_x_o, m_valid_o, m_y_o
   );

   modport master (
      output s_valid_i, s_x_i, arr_y_i, m_ready_i,
      input  s_ready_o, arr_x_o, m_valid_o, m_y_o
   );

endinterface

// File: rtl/syst_ws_fifo.sv
// Synchronous FIFO with a registered first-word output and an occupancy count.
module syst_ws_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    mem_count;
   logic             pop;
   logic             load;
   logic             take;
   logic             bypass;
   logic             wr_mem;

   // An empty output register is refilled from memory, or straight from the write port when memory is empty.
   always_comb begin
      pop    = rd_valid && rd_ready;
      load   = !rd_valid || pop;
      take   = load && (mem_count != '0);
      bypass = load && (mem_count == '0) && wr_en;
      wr_mem = wr_en && !bypass;
   end

   always_ff @(posedge clk_i) begin
      if (wr_mem) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         count     <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         if (wr_mem) wr_ptr <= wr_ptr + AW'(1);
         if (take) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
         end else if (bypass) begin
            rd_data <= wr_data;
         end
         if (load) rd_valid <= take || bypass;
         mem_count <= mem_count + CW'(wr_mem) - CW'(take);
         count     <= count + CW'(wr_en) - CW'(pop);
      end
   end

   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(wr_en && (count == CW'(DEPTH))));

endmodule

// File: rtl/syst_ws_stream.sv
// Skews input vectors onto the array x lanes, deskews row outputs and buffers results under credit control.
module syst_ws_stream
   import syst_ws_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   syst_ws_stream_if.slave bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam int unsigned NV = N_IN + N_OUT;
   localparam int unsigned FW = N_OUT * Y_WIDTH;

   logic          accept;
   logic          s_ready;
   logic          fifo_wr;
   logic          m_valid;
   logic [NV-1:0] vld;
   logic [CW-1:0] inflight;
   logic [CW-1:0] fifo_count;
   logic [SW-1:0] credit_used;
   x_vec_t        arr_x;
   y_vec_t        aligned;
   y_vec_t        m_y;

   // Every accepted vector holds a FIFO slot from acceptance onward, so a result always has room.
   assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
   assign s_ready     = credit_used < SW'(DEPTH);
   assign accept      = bus.s_valid_i && s_ready;
   assign fifo_wr     = vld[NV-1];

   // Lane k passes through k+1 registers; a bubble loads zero so idle slots drive 0.
   for (genvar k = 0; k < N_IN; k++) begin : g_skew
      logic [X_WIDTH-1:0] sr [k+1];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int d = 0; d <= k; d++) sr[d] <= '0;
         end else begin
            sr[0] <= accept ? bus.s_x_i[k] : '0;
            for (int d = 1; d <= k; d++) sr[d] <= sr[d-1];
         end
      end

      assign arr_x[k] = sr[k];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) vld <= '0;
      else       vld <= {vld[NV-2:0], accept};
   end

   // Row j leaves the array j cycles after row 0, so it is held N_OUT-1-j cycles to line up with the last row.
   for (genvar j = 0; j < N_OUT; j++) begin : g_deskew
      localparam int unsigned D = N_OUT - 1 - j;

      if (D == 0) begin : g_direct
         assign aligned[j] = bus.arr_y_i[j];
      end else begin : g_delay
         logic [Y_WIDTH-1:0] sr [D];

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int d = 0; d < int'(D); d++) sr[d] <= '0;
            end else begin
               sr[0] <= bus.arr_y_i[j];
               for (int d = 1; d < int'(D); d++) sr[d] <= sr[d-1];
            end
         end

         assign aligned[j] = sr[D-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)                     inflight <= '0;
      else if (accept && !fifo_wr)   inflight <= inflight + CW'(1);
      else if (!accept && fifo_wr)   inflight <= inflight - CW'(1);
   end

   syst_ws_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_en    (fifo_wr),
      .wr_data  (aligned),
      .rd_ready (bus.m_ready_i),
      .rd_valid (m_valid),
      .rd_data  (m_y),
      .count    (fifo_count)
   );

   assign bus.s_ready_o = s_ready;
   assign bus.arr_x_o   = arr_x;
   assign bus.m_valid_o = m_valid;
   assign bus.m_y_o     = m_y;

endmodule
